// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: synchronous FIFO with registered read data; the read word appears the cycle after rd_en.
module fifo_sync_ram #(
  parameter int W = 9,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [W-1:0] rd_data_q;
  logic push, pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign rd_data = rd_data_q;
  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      if (pop) rd_data_q <= mem[rptr_q];
    end
  end
  always_ff @(posedge clk) if (push) mem[wptr_q] <= wr_data;
endmodule

// File: rtl/lcd_phy_8080.sv
// lcd_phy_8080: 8080-style LCD write PHY with input FIFO, programmable strobe timing, CS idle release and FMARK strobe.
module lcd_phy_8080 #(
  parameter int DW = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int WR_LOW = 1,
  parameter int WR_HIGH = 1,
  parameter int CS_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] lcd_d,
  output logic          lcd_rs,
  output logic          lcd_wr_n,
  output logic          lcd_cs_n,
  input  logic          lcd_fmark,
  input  logic [DW-1:0] phy_data,
  input  logic          phy_rs,
  input  logic          phy_valid,
  output logic          phy_ready,
  output logic          phy_fmark_stb,
  output logic          phy_idle
);
  typedef enum logic [1:0] {IDLE, SETUP, LOW, HIGH} state_e;
  localparam int TW = $clog2(WR_LOW + WR_HIGH + CS_HOLD) + 1;
  state_e state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic cs_n_q, cs_n_d, wr_n_q, wr_n_d, pop_q, pop_d;
  logic [DW-1:0] d_q, d_d;
  logic rs_q, rs_d;
  logic sync1_q, sync2_q, prev_q, stb_q, stb_d;
  logic full, empty;
  logic [DW:0] rd_data;
  fifo_sync_ram #(.W(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(phy_valid),
    .wr_data({phy_rs, phy_data}),
    .rd_en(pop_d),
    .rd_data(rd_data),
    .full(full),
    .empty(empty)
  );
  // Pins are registered from the state, so they trail the FSM by one cycle.
  always_comb begin
    state_d = state_q;
    tcnt_d = tcnt_q;
    cs_n_d = cs_n_q;
    pop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          tcnt_d = '0;
          state_d = cs_n_q ? SETUP : LOW;
          pop_d = !cs_n_q;
        end else if (!cs_n_q) begin
          cs_n_d = tcnt_q == TW'(CS_HOLD - 1);
          tcnt_d = cs_n_d ? '0 : tcnt_q + TW'(1);
        end
      end
      SETUP: begin
        cs_n_d = 1'b0;
        pop_d = 1'b1;
        state_d = LOW;
      end
      LOW: begin
        state_d = tcnt_q == TW'(WR_LOW - 1) ? HIGH : LOW;
        tcnt_d = state_d == HIGH ? '0 : tcnt_q + TW'(1);
      end
      default: begin
        if (tcnt_q == TW'(WR_HIGH - 1)) begin
          tcnt_d = '0;
          pop_d = !empty;
          state_d = empty ? IDLE : LOW;
        end else tcnt_d = tcnt_q + TW'(1);
      end
    endcase
    wr_n_d = state_q != LOW;
    d_d = pop_q ? rd_data[DW-1:0] : d_q;
    rs_d = pop_q ? rd_data[DW] : rs_q;
    stb_d = sync2_q & ~prev_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q <= '0;
      cs_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      pop_q <= 1'b0;
      d_q <= '0;
      rs_q <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q <= 1'b0;
      stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q <= tcnt_d;
      cs_n_q <= cs_n_d;
      wr_n_q <= wr_n_d;
      pop_q <= pop_d;
      d_q <= d_d;
      rs_q <= rs_d;
      sync1_q <= lcd_fmark;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
      stb_q <= stb_d;
    end
  end
  assign lcd_d = d_q;
  assign lcd_rs = rs_q;
  assign lcd_wr_n = wr_n_q;
  assign lcd_cs_n = cs_n_q;
  assign phy_ready = !full;
  assign phy_fmark_stb = stb_q;
  assign phy_idle = empty && state_q == IDLE && cs_n_q;
endmodule
